// File: rtl/ula_issue_if.sv
// ula_issue_if
//  Bundles the issue-side handshake, load port, ULA operand/result bus and
//  debug read port of ula_issue into one interface.
//  Modports:
//   slave  - seen by ula_issue (instruction/load requests in, ULA operands out)
//   master - seen by the decode side / environment driving ula_issue
//  Signals:
//   instr_valid_in/instr_ready_out, op_in, rd_in, rs_in : instruction handshake
//   ld_valid_in/ld_ready_out, ld_addr_in, ld_data_in    : direct register load
//   ula_op_out, a_out, b_out, result_in                 : combinational ULA bus
//   done_out, zero_out, busy_out                        : status
//   dbg_addr_in, dbg_data_out                           : register-file peek
interface ula_issue_if #(
  parameter int ULA_OP   = 3,
  parameter int BITS     = 8,
  parameter int REG_ADDR = 2
);
  logic                instr_valid_in;
  logic                instr_ready_out;
  logic [ULA_OP-1:0]   op_in;
  logic [REG_ADDR-1:0] rd_in;
  logic [REG_ADDR-1:0] rs_in;
  logic                ld_valid_in;
  logic [REG_ADDR-1:0] ld_addr_in;
  logic [BITS-1:0]     ld_data_in;
  logic                ld_ready_out;
  logic [ULA_OP-1:0]   ula_op_out;
  logic [BITS-1:0]     a_out;
  logic [BITS-1:0]     b_out;
  logic [BITS-1:0]     result_in;
  logic                done_out;
  logic                zero_out;
  logic                busy_out;
  logic [REG_ADDR-1:0] dbg_addr_in;
  logic [BITS-1:0]     dbg_data_out;

  modport slave (
    input  instr_valid_in, op_in, rd_in, rs_in,
    input  ld_valid_in, ld_addr_in, ld_data_in,
    input  result_in, dbg_addr_in,
    output instr_ready_out, ld_ready_out, ula_op_out, a_out, b_out,
    output done_out, zero_out, busy_out, dbg_data_out
  );

  modport master (
    output instr_valid_in, op_in, rd_in, rs_in,
    output ld_valid_in, ld_addr_in, ld_data_in,
    output result_in, dbg_addr_in,
    input  instr_ready_out, ld_ready_out, ula_op_out, a_out, b_out,
    input  done_out, zero_out, busy_out, dbg_data_out
  );
endinterface

// File: rtl/ula_issue.sv
// ula_issue
//  Issue-side sequencer for an external combinational ULA. Accepts
//  rd <- rd OP rs instructions, reads both operands from the internal
//  register file, presents them to the ULA, captures the result and writes
//  it back to rd while updating the zero flag.
//  Sequence: IDLE -> READ -> EXEC -> WB -> IDLE (one instruction per 4 cycles).
//  Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - ula_issue_if.slave (handshake, load port, ULA bus, status, debug)
module ula_issue #(
  parameter int ULA_OP   = 3,
  parameter int BITS     = 8,
  parameter int REG_ADDR = 2
) (
  input  logic     clk,
  input  logic     rst,
  ula_issue_if.slave bus
);

  localparam int NREGS = 2 ** REG_ADDR;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [BITS-1:0]     r_regs [NREGS];
  logic [ULA_OP-1:0]   r_op;
  logic [REG_ADDR-1:0] r_rd;
  logic [REG_ADDR-1:0] r_rs;
  logic [ULA_OP-1:0]   r_ula_op;
  logic [BITS-1:0]     r_a;
  logic [BITS-1:0]     r_b;
  logic [BITS-1:0]     r_result;
  logic                r_zero;
  logic                w_idle;
  logic                w_accept;
  logic                w_load;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & bus.instr_valid_in;
  assign w_load   = w_idle & bus.ld_valid_in;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.instr_valid_in) w_next = S_READ;
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    bus.instr_ready_out = w_idle;
    bus.ld_ready_out    = w_idle;
    bus.busy_out        = ~w_idle;
    bus.done_out        = (r_state == S_WB);
  end

  // Register file. A load and an instruction accepted together both land at
  // the same edge; the operand read happens one cycle later in READ, so it
  // naturally observes the loaded value. Loads (IDLE) and write-back (WB)
  // can never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_load)             r_regs[bus.ld_addr_in] <= bus.ld_data_in;
      if (r_state == S_WB)    r_regs[r_rd]           <= r_result;
    end
  end

  // accept: latch the instruction fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0;
      r_rd <= '0;
      r_rs <= '0;
    end else if (w_accept) begin
      r_op <= bus.op_in;
      r_rd <= bus.rd_in;
      r_rs <= bus.rs_in;
    end
  end

  // READ -> EXEC: operands and opcode to the ULA; held until the next READ
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_ula_op <= '0;
    end else if (r_state == S_READ) begin
      r_a      <= r_regs[r_rd];
      r_b      <= r_regs[r_rs];
      r_ula_op <= r_op;
    end
  end

  // EXEC -> WB: capture the settled ULA result; WB -> IDLE: zero flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (r_state == S_EXEC) r_result <= bus.result_in;
      if (r_state == S_WB)   r_zero   <= (r_result == '0);
    end
  end

  assign bus.ula_op_out   = r_ula_op;
  assign bus.a_out        = r_a;
  assign bus.b_out        = r_b;
  assign bus.zero_out     = r_zero;
  assign bus.dbg_data_out = r_regs[bus.dbg_addr_in];

endmodule

// File: tb/tb_ula_issue.sv
// tb_ula_issue
//  Bench for ula_issue: supplies a combinational ULA on result_in, drives
//  directed instruction/load vectors, and checks every cycle against a
//  transaction-level model plus hand-computed literal expectations.
//  Bench ULA opcodes: 000 ~b, 001 a&b, 010 a|b, 011 a^b, 100 a+b, 101 a-b,
//  110 a<<b, 111 a>>b (all modulo 2**8).
module tb_ula_issue;
  localparam int ULA_OP   = 3;
  localparam int BITS     = 8;
  localparam int REG_ADDR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ula_issue_if #(.ULA_OP(ULA_OP), .BITS(BITS), .REG_ADDR(REG_ADDR)) bus ();

  ula_issue #(.ULA_OP(ULA_OP), .BITS(BITS), .REG_ADDR(REG_ADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  function automatic logic [BITS-1:0] ula_f(input logic [ULA_OP-1:0] op,
                                            input logic [BITS-1:0] a,
                                            input logic [BITS-1:0] b);
    case (op)
      3'd0: return ~b;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return a << b;
      default: return a >> b;
    endcase
  endfunction

  assign bus.result_in = ula_f(bus.ula_op_out, bus.a_out, bus.b_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted instruction computes its result
  // immediately from the register contents (after any same-cycle load),
  // then the outcome becomes visible on a fixed 3-cycle schedule.
  logic [BITS-1:0]     m_regs [4];
  int                  m_left;
  logic                m_zero;
  logic [BITS-1:0]     m_a, m_b, p_a, p_b, p_res;
  logic [ULA_OP-1:0]   m_op, p_op;
  logic [REG_ADDR-1:0] p_rd;

  function automatic logic [BITS-1:0] rd_after_ld(input logic [REG_ADDR-1:0] addr);
    if (bus.ld_valid_in && bus.ld_addr_in == addr) return bus.ld_data_in;
    return m_regs[addr];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= '0;
      m_left <= 0;
      m_zero <= 1'b0;
      m_a    <= '0;
      m_b    <= '0;
      m_op   <= '0;
    end else if (m_left != 0) begin
      if (m_left == 3) begin
        m_a  <= p_a;
        m_b  <= p_b;
        m_op <= p_op;
      end
      if (m_left == 1) begin
        m_regs[p_rd] <= p_res;
        m_zero       <= (p_res == '0);
      end
      m_left <= m_left - 1;
    end else begin
      if (bus.ld_valid_in) m_regs[bus.ld_addr_in] <= bus.ld_data_in;
      if (bus.instr_valid_in) begin
        p_a    <= rd_after_ld(bus.rd_in);
        p_b    <= rd_after_ld(bus.rs_in);
        p_op   <= bus.op_in;
        p_rd   <= bus.rd_in;
        p_res  <= ula_f(bus.op_in, rd_after_ld(bus.rd_in), rd_after_ld(bus.rs_in));
        m_left <= 3;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready",    32'(bus.instr_ready_out), 32'(m_left == 0));
      chk("ld_ready", 32'(bus.ld_ready_out),    32'(m_left == 0));
      chk("busy",     32'(bus.busy_out),        32'(m_left != 0));
      chk("done",     32'(bus.done_out),        32'(m_left == 1));
      chk("zero",     32'(bus.zero_out),        32'(m_zero));
      chk("a_out",    32'(bus.a_out),           32'(m_a));
      chk("b_out",    32'(bus.b_out),           32'(m_b));
      chk("ula_op",   32'(bus.ula_op_out),      32'(m_op));
      chk("dbg",      32'(bus.dbg_data_out),    32'(m_regs[bus.dbg_addr_in]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ld(input logic v, input logic [1:0] addr, input logic [7:0] data);
    bus.ld_valid_in = v;
    bus.ld_addr_in  = addr;
    bus.ld_data_in  = data;
  endtask

  task automatic instr(input logic v, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    bus.instr_valid_in = v;
    bus.op_in          = op;
    bus.rd_in          = rd;
    bus.rs_in          = rs;
  endtask

  task automatic peek(input logic [1:0] addr, input logic [7:0] exp, input string name);
    bus.dbg_addr_in = addr;
    #1;
    chk(name, 32'(bus.dbg_data_out), 32'(exp));
  endtask

  initial begin
    instr(1'b0, 3'd0, 2'd0, 2'd0);
    ld(1'b0, 2'd0, 8'h00);
    bus.dbg_addr_in = '0;
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.instr_ready_out), 32'd1);
    chk("rst_zero",  32'(bus.zero_out),        32'd0);
    chk("rst_busy",  32'(bus.busy_out),        32'd0);

    // 1: R0=0x0F, R1=0x03, add -> 0x12
    ld(1'b1, 2'd0, 8'h0F); tick();
    ld(1'b1, 2'd1, 8'h03); tick();
    ld(1'b0, 2'd0, 8'h00);
    instr(1'b1, 3'b100, 2'd0, 2'd1); tick();
    instr(1'b0, 3'd0, 2'd0, 2'd0);
    chk("t1_ready_read", 32'(bus.instr_ready_out), 32'd0);
    tick();
    chk("t1_a", 32'(bus.a_out), 32'h0F);
    chk("t1_b", 32'(bus.b_out), 32'h03);
    chk("t1_done_exec", 32'(bus.done_out), 32'd0);
    tick();
    chk("t1_done_wb", 32'(bus.done_out), 32'd1);
    tick();
    peek(2'd0, 8'h12, "t1_r0");
    chk("t1_zero", 32'(bus.zero_out), 32'd0);

    // 2: rd == rs, sub -> 0, zero set, done one cycle
    instr(1'b1, 3'b101, 2'd1, 2'd1); tick();
    instr(1'b0, 3'd0, 2'd0, 2'd0);
    tick(); tick();
    chk("t2_done_wb", 32'(bus.done_out), 32'd1);
    tick();
    chk("t2_done_after", 32'(bus.done_out), 32'd0);
    chk("t2_zero", 32'(bus.zero_out), 32'd1);
    peek(2'd1, 8'h00, "t2_r1");

    // 3: back-to-back shifts with valid held high
    ld(1'b1, 2'd2, 8'h01); tick();
    ld(1'b1, 2'd3, 8'h04); tick();
    ld(1'b0, 2'd0, 8'h00);
    instr(1'b1, 3'b110, 2'd2, 2'd3); tick();
    chk("t3_ready_t1", 32'(bus.instr_ready_out), 32'd0);
    tick(); tick(); tick();
    chk("t3_ready_t4", 32'(bus.instr_ready_out), 32'd1);
    peek(2'd2, 8'h10, "t3_r2_first");
    tick();
    instr(1'b0, 3'd0, 2'd0, 2'd0);
    chk("t3_second_accept", 32'(bus.busy_out), 32'd1);
    tick(); tick(); tick();
    peek(2'd2, 8'h00, "t3_r2_second");

    // 4: same-cycle load R3=0xAA + ~R3 into R2
    ld(1'b1, 2'd3, 8'hAA);
    instr(1'b1, 3'b000, 2'd2, 2'd3); tick();
    ld(1'b0, 2'd0, 8'h00);
    instr(1'b0, 3'd0, 2'd0, 2'd0);
    tick();
    chk("t4_b", 32'(bus.b_out), 32'hAA);
    tick(); tick();
    peek(2'd2, 8'h55, "t4_r2");

    // 6: load while busy is ignored
    ld(1'b1, 2'd1, 8'h33); tick();
    ld(1'b0, 2'd0, 8'h00);
    instr(1'b1, 3'b100, 2'd0, 2'd1); tick();
    instr(1'b0, 3'd0, 2'd0, 2'd0);
    tick();
    ld(1'b1, 2'd1, 8'h77);
    chk("t6_ld_ready", 32'(bus.ld_ready_out), 32'd0);
    tick(); tick();
    ld(1'b0, 2'd0, 8'h00);
    peek(2'd1, 8'h33, "t6_r1");
    peek(2'd0, 8'h45, "t6_r0");
    chk("t6_zero", 32'(bus.zero_out), 32'd0);

    // 5: reset during EXEC aborts the instruction
    instr(1'b1, 3'b100, 2'd0, 2'd1); tick();
    instr(1'b0, 3'd0, 2'd0, 2'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_done", 32'(bus.done_out), 32'd0);
    chk("t5_ready", 32'(bus.instr_ready_out), 32'd1);
    chk("t5_busy", 32'(bus.busy_out), 32'd0);
    for (int i = 0; i < 4; i++) peek(2'(i), 8'h00, "t5_reg_clear");
    tick(); tick(); tick();
    chk("t5_no_done", 32'(bus.done_out), 32'd0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
